mips_dmem_responder: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 39 +++
 rtl/mips_byte_lane.sv | 81 ++++++++
 rtl/mips_dmem_responder.sv | 174 +++++++++++++++++
 tb/tb_mips_dmem_responder.sv | 527 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder.
//   - Opcode constants for the MIPS load/store instructions handled by the responder.
//   - FSM state encoding for the request/response sequencer.
//   - Access-size enum used by the byte-lane logic.
package mips_mem_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LL  = 6'b110000;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SC  = 6'b111000;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StExec,
    StResp
  } state_e;

  typedef enum logic [1:0] {
    SizeByte,
    SizeHalf,
    SizeWord
  } size_e;

  // Plain loads whose response carries extracted read data.
  function automatic logic op_is_load(logic [5:0] op);
    return (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU) || (op == OP_LL);
  endfunction

  // Unconditional stores (sc is handled separately).
  function automatic logic op_is_store(logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_byte_lane.sv
// Combinational byte-lane unit for the data-memory responder.
// Ports:
//   op         - MIPS opcode of the access
//   addr_lo    - byte offset within the word (addr[1:0])
//   old_word   - current contents of the addressed word
//   wdata      - store data from rt
//   store_word - old_word with the store's lanes merged in
//   load_data  - zero-extended load value (0 on error)
//   err        - misaligned access or unsupported opcode
module mips_byte_lane
  import mips_mem_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] store_word,
  output logic [31:0] load_data,
  output logic        err
);

  size_e       size;
  logic        legal;
  logic        misalign;
  logic [4:0]  sh_amt;
  logic [31:0] shifted;
  logic [31:0] mask;
  logic [31:0] lane_data;

  always_comb begin
    legal = 1'b1;
    size  = SizeWord;
    case (op)
      OP_LBU, OP_SB:              size = SizeByte;
      OP_LHU, OP_SH:              size = SizeHalf;
      OP_LW, OP_LL, OP_SW, OP_SC: size = SizeWord;
      default:                    legal = 1'b0;
    endcase
  end

  always_comb begin
    case (size)
      SizeHalf: misalign = addr_lo[0];
      SizeWord: misalign = (addr_lo != 2'b00);
      default:  misalign = 1'b0;
    endcase
  end

  assign err = !legal || misalign;

  // Aligned halfwords have addr_lo[0]=0, so one byte-granular shift serves every size.
  assign sh_amt  = {addr_lo, 3'b000};
  assign shifted = old_word >> sh_amt;

  always_comb begin
    load_data = 32'h0;
    mask      = 32'hFFFF_FFFF;
    lane_data = wdata;
    case (size)
      SizeByte: begin
        load_data = {24'h0, shifted[7:0]};
        mask      = 32'h0000_00FF << sh_amt;
        lane_data = {4{wdata[7:0]}};
      end
      SizeHalf: begin
        load_data = {16'h0, shifted[15:0]};
        mask      = 32'h0000_FFFF << sh_amt;
        lane_data = {2{wdata[15:0]}};
      end
      default: begin
        load_data = old_word;
      end
    endcase
    if (err) begin
      load_data = 32'h0;
    end
  end

  assign store_word = (old_word & ~mask) | (lane_data & mask);

endmodule

// File: rtl/mips_dmem_responder.sv
// Memory-side responder for the core's data-memory port.
// Accepts one load/store at a time, optionally inserts WAIT_CYCLES busy cycles, performs the
// access on an internal word array in a single EXEC cycle and holds the response until taken.
// Implements the LL/SC reservation and misalignment/illegal-opcode errors.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   req_valid/req_ready - request handshake (ready only in IDLE)
//   req_op/addr/wdata   - opcode, byte address, store data
//   rsp_valid/rsp_ready - response handshake
//   rsp_rdata           - load data or SC status, 0 for stores and errors
//   rsp_err             - misaligned or unsupported access
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam logic [3:0]  WaitLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e              state_q;
  logic [5:0]          op_q;
  logic [IdxW+1:0]     addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          cnt_q;
  logic                resv_valid_q;
  logic [IdxW-1:0]     resv_idx_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_err_q;

  logic [31:0]         mem [DEPTH];

  logic [IdxW-1:0]     idx;
  logic [31:0]         old_word;
  logic [31:0]         store_word;
  logic [31:0]         load_data;
  logic                lane_err;
  logic                is_load;
  logic                is_store;
  logic                is_ll;
  logic                is_sc;
  logic                sc_ok;
  logic                mem_we;
  logic [31:0]         exec_rdata;

  // Upper address bits alias the array and are intentionally dropped.
  logic                unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:IdxW+2];

  assign idx      = addr_q[IdxW+1:2];
  assign old_word = mem[idx];

  mips_byte_lane u_lane (
    .op         (op_q),
    .addr_lo    (addr_q[1:0]),
    .old_word   (old_word),
    .wdata      (wdata_q),
    .store_word (store_word),
    .load_data  (load_data),
    .err        (lane_err)
  );

  assign is_load  = op_is_load(op_q);
  assign is_store = op_is_store(op_q);
  assign is_ll    = (op_q == OP_LL);
  assign is_sc    = (op_q == OP_SC);
  assign sc_ok    = is_sc && resv_valid_q && (resv_idx_q == idx);
  assign mem_we   = (state_q == StExec) && !lane_err && (is_store || sc_ok);

  always_comb begin
    exec_rdata = 32'h0;
    if (!lane_err) begin
      if (is_load) begin
        exec_rdata = load_data;
      end else if (is_sc) begin
        exec_rdata = {31'h0, sc_ok};
      end
    end
  end

  // Array is not reset; it only changes on the EXEC edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= store_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      op_q         <= 6'h0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      cnt_q        <= 4'd0;
      resv_valid_q <= 1'b0;
      resv_idx_q   <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q        <= req_op;
            addr_q      <= req_addr[IdxW+1:0];
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state_q <= StBusy;
              cnt_q   <= WaitLoad;
            end else begin
              state_q <= StExec;
            end
          end
        end
        StBusy: begin
          if (cnt_q == 4'd0) begin
            state_q <= StExec;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StExec: begin
          state_q     <= StResp;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= exec_rdata;
          rsp_err_q   <= lane_err;
          // Faulting accesses leave the reservation alone.
          if (!lane_err) begin
            if (is_ll) begin
              resv_valid_q <= 1'b1;
              resv_idx_q   <= idx;
            end else if (is_sc) begin
              resv_valid_q <= 1'b0;
            end else if (is_store && (idx == resv_idx_q)) begin
              resv_valid_q <= 1'b0;
            end
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
module tb_mips_dmem_responder;
  import mips_mem_pkg::*;

  localparam int unsigned Depth = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Main DUT, WAIT_CYCLES=3
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_op    = 6'h0;
  logic [31:0] req_addr  = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Second DUT, WAIT_CYCLES=0
  logic        z_req_valid = 1'b0;
  logic        z_req_ready;
  logic [5:0]  z_req_op    = 6'h0;
  logic [31:0] z_req_addr  = 32'h0;
  logic [31:0] z_req_wdata = 32'h0;
  logic        z_rsp_valid;
  logic        z_rsp_ready = 1'b0;
  logic [31:0] z_rsp_rdata;
  logic        z_rsp_err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mips_dmem_responder #(
    .DEPTH       (Depth),
    .WAIT_CYCLES (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  mips_dmem_responder #(
    .DEPTH       (Depth),
    .WAIT_CYCLES (0)
  ) dut0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (z_req_valid),
    .req_ready (z_req_ready),
    .req_op    (z_req_op),
    .req_addr  (z_req_addr),
    .req_wdata (z_req_wdata),
    .rsp_valid (z_rsp_valid),
    .rsp_ready (z_rsp_ready),
    .rsp_rdata (z_rsp_rdata),
    .rsp_err   (z_rsp_err)
  );

  // One full transaction on the main DUT. lat counts edges from the accepting edge (=1)
  // up to the edge after which rsp_valid is first seen high.
  task automatic xact(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = n;
    if (!rsp_valid) begin
      compared++;
      mismatched++;
      $display("FAIL xact_timeout op=%b addr=%h: no rsp_valid within %0d edges", op, addr, n);
      rd = 32'hx;
      er = 1'bx;
    end else begin
      rd = rsp_rdata;
      er = rsp_err;
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic zxact(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    z_req_op    = op;
    z_req_addr  = addr;
    z_req_wdata = wd;
    z_req_valid = 1'b1;
    @(posedge clk);
    #1;
    z_req_valid = 1'b0;
    n = 1;
    while (!z_rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = n;
    if (!z_rsp_valid) begin
      compared++;
      mismatched++;
      $display("FAIL zxact_timeout op=%b addr=%h: no rsp_valid within %0d edges", op, addr, n);
      rd = 32'hx;
      er = 1'bx;
    end else begin
      rd = z_rsp_rdata;
      er = z_rsp_err;
      @(negedge clk);
      z_rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      z_rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_req_ready got=%b want=1", req_ready);
    end
    compared++;
    if (rsp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid);
    end
    compared++;
    if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_rsp_data got=%h/%b want=00000000/0", rsp_rdata, rsp_err);
    end
    compared++;
    if (z_req_ready !== 1'b1 || z_rsp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_dut0 got ready=%b valid=%b want 1/0", z_req_ready, z_rsp_valid);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(OP_SW, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
    compared++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      mismatched++;
      $display("FAIL sw_rsp got=%h/%b want=00000000/0", rd, er);
    end
    xact(OP_LW, 32'h10, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      mismatched++;
      $display("FAIL lw_10 got=%h/%b want=deadbeef/0", rd, er);
    end
    xact(OP_LBU, 32'h13, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'h0000_00DE || er !== 1'b0) begin
      mismatched++;
      $display("FAIL lbu_13 got=%h/%b want=000000de/0", rd, er);
    end
    xact(OP_LHU, 32'h12, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'h0000_DEAD || er !== 1'b0) begin
      mismatched++;
      $display("FAIL lhu_12 got=%h/%b want=0000dead/0", rd, er);
    end
    xact(OP_LBU, 32'h10, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'h0000_00EF) begin
      mismatched++;
      $display("FAIL lbu_10 got=%h want=000000ef", rd);
    end
    xact(OP_LHU, 32'h10, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'h0000_BEEF) begin
      mismatched++;
      $display("FAIL lhu_10 got=%h want=0000beef", rd);
    end
  endtask

  task automatic test_byte_merge();
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(OP_SW, 32'h20, 32'h1122_3344, rd, er, lat);
    xact(OP_SB, 32'h21, 32'hFFFF_FFAB, rd, er, lat);
    xact(OP_LW, 32'h20, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'h1122_AB44) begin
      mismatched++;
      $display("FAIL sb_merge got=%h want=1122ab44", rd);
    end
    xact(OP_SH, 32'h22, 32'h5555_CAFE, rd, er, lat);
    xact(OP_LW, 32'h20, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'hCAFE_AB44) begin
      mismatched++;
      $display("FAIL sh_merge got=%h want=cafeab44", rd);
    end
  endtask

  task automatic test_llsc();
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(OP_SW, 32'h40, 32'h1234_5678, rd, er, lat);
    xact(OP_LL, 32'h40, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'h1234_5678 || er !== 1'b0) begin
      mismatched++;
      $display("FAIL ll_data got=%h/%b want=12345678/0", rd, er);
    end
    xact(OP_SC, 32'h40, 32'h5, rd, er, lat);
    compared++;
    if (rd !== 32'h1) begin
      mismatched++;
      $display("FAIL sc_success got=%h want=00000001", rd);
    end
    xact(OP_LW, 32'h40, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'h5) begin
      mismatched++;
      $display("FAIL sc_wrote got=%h want=00000005", rd);
    end
    xact(OP_SC, 32'h40, 32'h7, rd, er, lat);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL sc_second got=%h want=00000000", rd);
    end
    xact(OP_LW, 32'h40, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'h5) begin
      mismatched++;
      $display("FAIL sc_fail_nowrite got=%h want=00000005", rd);
    end
    // Intervening store to the reserved word kills the reservation
    xact(OP_LL, 32'h40, 32'h0, rd, er, lat);
    xact(OP_SW, 32'h40, 32'h66, rd, er, lat);
    xact(OP_SC, 32'h40, 32'h77, rd, er, lat);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL sc_after_sw got=%h want=00000000", rd);
    end
    xact(OP_LW, 32'h40, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'h66) begin
      mismatched++;
      $display("FAIL sc_after_sw_mem got=%h want=00000066", rd);
    end
    // Index mismatch fails
    xact(OP_LL, 32'h40, 32'h0, rd, er, lat);
    xact(OP_SC, 32'h44, 32'h99, rd, er, lat);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL sc_other_idx got=%h want=00000000", rd);
    end
    // Store to a different word leaves the reservation intact
    xact(OP_LL, 32'h40, 32'h0, rd, er, lat);
    xact(OP_SW, 32'h44, 32'h1, rd, er, lat);
    xact(OP_SC, 32'h40, 32'h88, rd, er, lat);
    compared++;
    if (rd !== 32'h1) begin
      mismatched++;
      $display("FAIL sc_after_other_sw got=%h want=00000001", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(OP_LW, 32'h41, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      mismatched++;
      $display("FAIL lw_misalign got=%h/%b want=00000000/1", rd, er);
    end
    xact(OP_SH, 32'h23, 32'h0000_1234, rd, er, lat);
    compared++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      mismatched++;
      $display("FAIL sh_misalign got=%h/%b want=00000000/1", rd, er);
    end
    xact(OP_LW, 32'h20, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'hCAFE_AB44) begin
      mismatched++;
      $display("FAIL sh_misalign_nowrite got=%h want=cafeab44", rd);
    end
    xact(6'b000000, 32'h20, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      mismatched++;
      $display("FAIL illegal_op got=%h/%b want=00000000/1", rd, er);
    end
    xact(OP_LHU, 32'h11, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      mismatched++;
      $display("FAIL lhu_misalign got=%h/%b want=00000000/1", rd, er);
    end
    xact(OP_LBU, 32'h23, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'h0000_00CA || er !== 1'b0) begin
      mismatched++;
      $display("FAIL lbu_23 got=%h/%b want=000000ca/0", rd, er);
    end
    // A faulting sc must not consume the reservation
    xact(OP_LL, 32'h40, 32'h0, rd, er, lat);
    xact(OP_SC, 32'h42, 32'h3, rd, er, lat);
    compared++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      mismatched++;
      $display("FAIL sc_misalign got=%h/%b want=00000000/1", rd, er);
    end
    xact(OP_SC, 32'h40, 32'h3, rd, er, lat);
    compared++;
    if (rd !== 32'h1) begin
      mismatched++;
      $display("FAIL sc_after_err got=%h want=00000001", rd);
    end
  endtask

  task automatic test_latency_stall();
    logic [31:0] rd;
    logic [31:0] rd0;
    logic        er;
    logic        er0;
    int          lat;
    int          n;
    xact(OP_LW, 32'h10, 32'h0, rd, er, lat);
    compared++;
    if (lat !== 5) begin
      mismatched++;
      $display("FAIL latency_wait3 got=%0d want=5", lat);
    end
    @(negedge clk);
    req_op    = OP_LW;
    req_addr  = 32'h10;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    compared++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL stall_rsp got=%b/%h want=1/deadbeef", rsp_valid, rsp_rdata);
    end
    rd0 = rsp_rdata;
    er0 = rsp_err;
    // Competing request while the response is held must be ignored
    req_valid = 1'b1;
    req_op    = OP_SW;
    req_addr  = 32'h10;
    req_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      compared++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd0 || rsp_err !== er0 || req_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_hold cyc=%0d got v=%b d=%h e=%b rdy=%b want v=1 d=%h e=%b rdy=0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready, rd0, er0);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    compared++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_release got rdy=%b v=%b want 1/0", req_ready, rsp_valid);
    end
    xact(OP_LW, 32'h10, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL ignored_req_nowrite got=%h want=deadbeef", rd);
    end
  endtask

  task automatic test_alias();
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(OP_LW, Depth * 4 + 32'h10, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      mismatched++;
      $display("FAIL alias_lw got=%h/%b want=deadbeef/0", rd, er);
    end
    xact(OP_SW, 32'hF000_0000 + Depth * 8 + 32'h50, 32'h0BAD_F00D, rd, er, lat);
    xact(OP_LW, 32'h50, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'h0BAD_F00D) begin
      mismatched++;
      $display("FAIL alias_sw got=%h want=0badf00d", rd);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(OP_SW, 32'h30, 32'h0000_0077, rd, er, lat);
    xact(OP_LL, 32'h30, 32'h0, rd, er, lat);
    @(negedge clk);
    req_op    = OP_SW;
    req_addr  = 32'h30;
    req_wdata = 32'h1;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL midop_reset got v=%b rdy=%b want 0/1", rsp_valid, req_ready);
    end
    repeat (6) @(posedge clk);
    #1;
    compared++;
    if (rsp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL midop_no_rsp got=%b want=0", rsp_valid);
    end
    xact(OP_LW, 32'h30, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'h0000_0077) begin
      mismatched++;
      $display("FAIL midop_mem got=%h want=00000077", rd);
    end
    xact(OP_SC, 32'h30, 32'h9, rd, er, lat);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL midop_resv got=%h want=00000000", rd);
    end
  endtask

  task automatic test_nowait();
    logic [31:0] rd;
    logic        er;
    int          lat;
    zxact(OP_SW, 32'h8, 32'hA5A5_0F0F, rd, er, lat);
    compared++;
    if (lat !== 2) begin
      mismatched++;
      $display("FAIL latency_wait0_sw got=%0d want=2", lat);
    end
    zxact(OP_LW, 32'h8, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'hA5A5_0F0F || lat !== 2) begin
      mismatched++;
      $display("FAIL wait0_lw got=%h lat=%0d want=a5a50f0f lat=2", rd, lat);
    end
    zxact(OP_LHU, 32'hA, 32'h0, rd, er, lat);
    compared++;
    if (rd !== 32'h0000_A5A5) begin
      mismatched++;
      $display("FAIL wait0_lhu got=%h want=0000a5a5", rd);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_merge();
    test_llsc();
    test_errors();
    test_latency_stall();
    test_alias();
    test_reset_midop();
    test_nowait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
